// File: rtl/gcd_lcm_stage.sv
// gcd_lcm_stage: turns an operand pair and its gcd into lcm = (xin*yin)/gin
// using a sequential restoring divider (one quotient bit per clock), with a
// valid/ready handshake on both the operand side and the result side.
module gcd_lcm_stage #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     xin,
  input  logic [WIDTH-1:0]     yin,
  input  logic [WIDTH-1:0]     gin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   lcm,
  output logic [WIDTH-1:0]     rem,
  output logic                 div_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(PW - 1);

  logic [1:0]        state;
  logic [WIDTH-1:0]  divisor;
  logic [PW-1:0]     quo;        // dividend bits shift out at the top, quotient bits in at the bottom
  logic [WIDTH:0]    rmd;        // one spare bit so the shifted remainder never overflows the compare
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              release_out;
  logic [PW-1:0]     product;
  logic [WIDTH:0]    rmd_shift;
  logic [WIDTH:0]    rmd_next;
  logic [PW-1:0]     quo_next;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign product     = PW'(xin) * PW'(yin);

  // One restoring shift-subtract step on the current divider state.
  always_comb begin
    rmd_shift = {rmd[WIDTH-1:0], quo[PW-1]};
    rmd_next  = rmd_shift;
    quo_next  = {quo[PW-2:0], 1'b0};
    if (rmd_shift >= {1'b0, divisor}) begin
      rmd_next = rmd_shift - {1'b0, divisor};
      quo_next = {quo[PW-2:0], 1'b1};
    end
  end

  // Control FSM plus divider datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      divisor <= '0;
      quo     <= '0;
      rmd     <= '0;
      cnt     <= '0;
      lcm     <= '0;
      rem     <= '0;
      div_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            divisor <= gin;
            quo     <= product;
            rmd     <= '0;
            cnt     <= '0;
            if (gin == '0) begin
              lcm     <= '0;
              rem     <= '0;
              div_err <= 1'b1;
              state   <= DONE;
            end else begin
              state   <= DIV;
            end
          end
        end
        DIV: begin
          quo <= quo_next;
          rmd <= rmd_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            lcm     <= quo_next;
            rem     <= rmd_next[WIDTH-1:0];
            div_err <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (release_out) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_stage.sv
// Directed bench for gcd_lcm_stage (WIDTH=4) with hand-computed expectations.
module tb_gcd_lcm_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] xin, yin, gin;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] lcm;
  logic [3:0] rem;
  logic       div_err;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  gcd_lcm_stage #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .xin(xin), .yin(yin), .gin(gin),
    .in_valid(in_valid), .in_ready(in_ready), .lcm(lcm), .rem(rem),
    .div_err(div_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, counting edges after the accept edge.
  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  // Full transaction: accept, wait, check result, then handshake it away.
  task automatic run(input string tag, input logic [3:0] x, input logic [3:0] y,
                     input logic [3:0] g, input int exp_lat, input logic [7:0] exp_lcm,
                     input logic [3:0] exp_rem, input logic exp_err);
    xin = x; yin = y; gin = g; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_result(tag, exp_lat);
    chk({tag, "_lcm"}, lcm, exp_lcm);
    chk({tag, "_rem"}, rem, exp_rem);
    chk({tag, "_err"}, div_err, exp_err);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_idle_ovalid"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    xin = '0; yin = '0; gin = '0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lcm", lcm, 0);
    chk("rst_rem", rem, 0);
    chk("rst_div_err", div_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic and boundary operand sets
    run("basic", 4'd12, 4'd8, 4'd4, 8, 8'd24, 4'd0, 1'b0);
    run("max1", 4'd15, 4'd14, 4'd1, 8, 8'd210, 4'd0, 1'b0);
    run("max2", 4'd15, 4'd15, 4'd15, 8, 8'd15, 4'd0, 1'b0);
    run("gzero", 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, 1'b1);
    run("nondiv", 4'd6, 4'd4, 4'd5, 8, 8'd4, 4'd4, 1'b0);
    run("xzero", 4'd0, 4'd7, 4'd3, 8, 8'd0, 4'd0, 1'b0);

    // Backpressure: hold result under out_ready=0 while in_valid stays high
    xin = 4'd3; yin = 4'd4; gin = 4'd2; in_valid = 1'b1;
    tick();
    xin = 4'd9; yin = 4'd9; gin = 4'd3;
    wait_result("bp", 8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ovalid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_lcm", lcm, 6);
      chk("bp_rem", rem, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_ovalid", out_valid, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("bp_no_accept", in_ready, 1);

    // Reset in the 4th DIV cycle
    xin = 4'd12; yin = 4'd8; gin = 4'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_lcm", lcm, 0);
    chk("mid_rst_rem", rem, 0);
    chk("mid_rst_err", div_err, 0);
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_idle", in_ready, 1);
    chk("post_rst_ovalid", out_valid, 0);
    run("post_rst", 4'd3, 4'd5, 4'd1, 8, 8'd15, 4'd0, 1'b0);

    // Back-to-back stream with in_valid and out_ready held high
    out_ready = 1'b1; in_valid = 1'b1;
    xin = 4'd5; yin = 4'd3; gin = 4'd1;
    tick();
    chk("b2b_acc0", in_ready, 0);
    wait_result("b2b0", 8);
    chk("b2b0_lcm", lcm, 15);
    xin = 4'd4; yin = 4'd6; gin = 4'd2;
    tick();
    chk("b2b_hs0", in_ready, 1);
    tick();
    chk("b2b_acc1", in_ready, 0);
    wait_result("b2b1", 8);
    chk("b2b1_lcm", lcm, 12);
    xin = 4'd7; yin = 4'd7; gin = 4'd7;
    tick();
    chk("b2b_hs1", in_ready, 1);
    tick();
    chk("b2b_acc2", in_ready, 0);
    wait_result("b2b2", 8);
    chk("b2b2_lcm", lcm, 7);
    chk("b2b2_rem", rem, 0);
    tick();
    in_valid = 1'b0;
    chk("b2b_hs2", in_ready, 1);
    tick();
    chk("b2b_end_idle", in_ready, 1);
    chk("b2b_end_ovalid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
